// File: rtl/local_store_pkg.sv
// Shared widths, request/response bundles and address helpers for the SPU local store.
package local_store_pkg;

  localparam int LS_ADDR_WIDTH   = 15;
  localparam int LS_DEPTH        = 2048;
  localparam int LS_LOAD_LATENCY = 6;
  localparam int REG_ADDR_WIDTH  = 7;
  localparam int LS_DATA_WIDTH   = 128;
  localparam int LS_INDEX_WIDTH  = $clog2(LS_DEPTH);

  typedef struct packed {
    logic [0:LS_ADDR_WIDTH-1]  addr;
    logic                      wrt_en;
    logic                      rd_en;
    logic [0:LS_DATA_WIDTH-1]  wrt_data;
    logic [0:REG_ADDR_WIDTH-1] tag;
  } ls_req_t;

  typedef struct packed {
    logic [0:LS_DATA_WIDTH-1]  rd_data;
    logic                      rd_valid;
    logic [0:REG_ADDR_WIDTH-1] rd_tag;
  } ls_rsp_t;

  // Bit 0 is the MSB, so the quadword index is the leading slice of the address.
  function automatic logic [0:LS_INDEX_WIDTH-1] ls_index(input logic [0:LS_ADDR_WIDTH-1] addr);
    return addr[0:LS_INDEX_WIDTH-1];
  endfunction

endpackage

// File: rtl/local_store_delay_line.sv
// LATENCY-deep {valid, data, tag} shift register; flush and reset clear the valid bits.
module ls_delay_line #(
  parameter int LATENCY    = 6,
  parameter int DATA_WIDTH = 128,
  parameter int TAG_WIDTH  = 7
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic                  in_valid_i,
  input  logic [0:DATA_WIDTH-1] in_data_i,
  input  logic [0:TAG_WIDTH-1]  in_tag_i,
  output logic                  out_valid_o,
  output logic [0:DATA_WIDTH-1] out_data_o,
  output logic [0:TAG_WIDTH-1]  out_tag_o
);

  logic [LATENCY-1:0]    valid_q, valid_d;
  logic [0:DATA_WIDTH-1] data_q [LATENCY];
  logic [0:DATA_WIDTH-1] data_d [LATENCY];
  logic [0:TAG_WIDTH-1]  tag_q  [LATENCY];
  logic [0:TAG_WIDTH-1]  tag_d  [LATENCY];

  // Payload only advances behind a valid bit, so the output holds its last value when idle.
  always_comb begin
    valid_d = '0;
    data_d  = data_q;
    tag_d   = tag_q;
    if (!flush_i) begin
      valid_d[0] = in_valid_i;
      if (in_valid_i) begin
        data_d[0] = in_data_i;
        tag_d[0]  = in_tag_i;
      end
      for (int i = 1; i < LATENCY; i++) begin
        valid_d[i] = valid_q[i-1];
        if (valid_q[i-1]) begin
          data_d[i] = data_q[i-1];
          tag_d[i]  = tag_q[i-1];
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        data_q[i] <= '0;
        tag_q[i]  <= '0;
      end
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      tag_q   <= tag_d;
    end
  end

  assign out_valid_o = valid_q[LATENCY-1];
  assign out_data_o  = data_q[LATENCY-1];
  assign out_tag_o   = tag_q[LATENCY-1];

endmodule

// File: rtl/local_store.sv
// 32 KB single-port quadword local store answering the odd pipe's loads and stores.
module local_store
  import local_store_pkg::*;
#(
  parameter int ADDR_WIDTH   = LS_ADDR_WIDTH,
  parameter int DATA_WIDTH   = LS_DATA_WIDTH,
  parameter int LOAD_LATENCY = LS_LOAD_LATENCY,
  parameter int TAG_WIDTH    = REG_ADDR_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [0:ADDR_WIDTH-1] LS_address,
  input  logic                  LS_wrt_en,
  input  logic                  LS_rd_en,
  input  logic [0:DATA_WIDTH-1] LS_wrt_data,
  input  logic [0:TAG_WIDTH-1]  LS_rd_tag_in,
  input  logic                  LS_flush,
  output logic [0:DATA_WIDTH-1] LS_rd_data,
  output logic                  LS_rd_valid,
  output logic [0:TAG_WIDTH-1]  LS_rd_tag_out,
  output logic                  LS_conflict
);

  localparam int DEPTH = 2 ** (ADDR_WIDTH - 4);

  // Handshake: no backpressure. A request is taken on any edge where its enable is high;
  // a response is offered for exactly one cycle with LS_rd_valid and must be consumed then.
  ls_req_t                   req;
  ls_rsp_t                   rsp;
  logic [0:LS_INDEX_WIDTH-1] index;
  logic [0:DATA_WIDTH-1]     mem_q [DEPTH];
  logic                      load_issue;
  logic                      unused_addr_bits;

  // Array read register: captures pre-store contents at the issue edge.
  logic                  rd_valid_q, rd_valid_d;
  logic [0:DATA_WIDTH-1] rd_data_q, rd_data_d;
  logic [0:TAG_WIDTH-1]  rd_tag_q, rd_tag_d;
  logic                  conflict_q, conflict_d;

  assign req = '{addr: LS_address, wrt_en: LS_wrt_en, rd_en: LS_rd_en,
                 wrt_data: LS_wrt_data, tag: LS_rd_tag_in};

  assign index            = ls_index(req.addr);
  assign unused_addr_bits = ^req.addr[LS_INDEX_WIDTH:LS_ADDR_WIDTH-1];
  assign load_issue       = req.rd_en && !req.wrt_en;

  always_ff @(posedge clock) begin
    if (req.wrt_en) mem_q[index] <= req.wrt_data;
  end

  always_comb begin
    rd_valid_d = load_issue && !LS_flush;
    rd_data_d  = rd_data_q;
    rd_tag_d   = rd_tag_q;
    if (load_issue) begin
      rd_data_d = mem_q[index];
      rd_tag_d  = req.tag;
    end
    conflict_d = req.rd_en && req.wrt_en;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      rd_tag_q   <= '0;
      conflict_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      rd_tag_q   <= rd_tag_d;
      conflict_q <= conflict_d;
    end
  end

  ls_delay_line #(
    .LATENCY    (LOAD_LATENCY),
    .DATA_WIDTH (DATA_WIDTH),
    .TAG_WIDTH  (TAG_WIDTH)
  ) u_delay_line (
    .clk_i       (clock),
    .rst_i       (reset),
    .flush_i     (LS_flush),
    .in_valid_i  (rd_valid_q),
    .in_data_i   (rd_data_q),
    .in_tag_i    (rd_tag_q),
    .out_valid_o (rsp.rd_valid),
    .out_data_o  (rsp.rd_data),
    .out_tag_o   (rsp.rd_tag)
  );

  assign LS_rd_data    = rsp.rd_data;
  assign LS_rd_valid   = rsp.rd_valid;
  assign LS_rd_tag_out = rsp.rd_tag;
  assign LS_conflict   = conflict_q;

endmodule
